// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline types and constants.
//
// Contents:
//   rv32_if_packet_t      fetch-to-decode packet {pc, instruction}
//   rv32_branch_packet_t  branch resolution packet; branch_taken drives queue flushes
//   RV32_NOP              canonical no-op (addi x0,x0,0)
//   RV32_IDLE_IF_PACKET   packet presented to decode when nothing valid is queued
//   IFQ_DEPTH_DEFAULT     default depth of the fetch/decode instruction queue
package rv32_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } rv32_if_packet_t;

  typedef struct packed {
    logic        branch_taken;
    logic [31:0] branch_target;
  } rv32_branch_packet_t;

  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  localparam rv32_if_packet_t RV32_IDLE_IF_PACKET = '{pc: 32'h0, instruction: RV32_NOP};

  localparam int IFQ_DEPTH_DEFAULT = 2;

endpackage

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode.
//
// Captures {pc, instruction} packets from fetch and presents them in order to
// decode over a valid/ready handshake. Occupancy (count) doubles as the state:
// EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-high reset
//   if_packet_in    packet from fetch
//   if_valid        if_packet_in is a real fetched instruction
//   flush           branch redirect; discards all queued entries
//   id_ready        decode accepts the head entry this cycle
//   id_packet_out   head entry (idle NOP packet when empty)
//   id_valid        id_packet_out is valid
//   stall_fetch     queue full; fetch must hold its PC
//   overflow_err    sticky: a packet arrived while full with no pop
//   flush_drop_cnt  (only with IFQ_PERF_CNT_EN) saturating count of entries
//                   discarded by flushes
//
// Optional feature macro: IFQ_PERF_CNT_EN
module if_id_queue
  import rv32_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  rv32_if_packet_t if_packet_in,
  input  logic            if_valid,
  input  logic            flush,
  input  logic            id_ready,
  output rv32_if_packet_t id_packet_out,
  output logic            id_valid,
  output logic            stall_fetch,
  output logic            overflow_err
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0]     flush_drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = (PTR_W)'(1);
  localparam logic [PTR_W:0] CNT_ONE = (PTR_W + 1)'(1);

  rv32_if_packet_t mem_q [DEPTH];
  rv32_if_packet_t mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             push, pop;

  // Outputs depend on registered state only, so there is no path from
  // id_ready or the fetch inputs to stall_fetch/id_valid/id_packet_out.
  assign id_valid      = (count_q != '0);
  assign stall_fetch   = (count_q == FULL_CNT);
  assign id_packet_out = id_valid ? mem_q[rd_ptr_q] : RV32_IDLE_IF_PACKET;
  assign overflow_err  = overflow_q;

  // A pop frees a slot in the same cycle, so a full queue still accepts a push
  // when decode is draining it.
  assign pop  = id_valid & id_ready;
  assign push = if_valid & ~flush & (~stall_fetch | pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = if_packet_in;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A flush wins over push/pop bookkeeping. A same-cycle pop has already
    // been sampled by decode; its kill logic owns that instruction.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Overflow only counts packets that could have been stored: flushed
  // packets are dropped on purpose and do not set the flag.
  always_comb begin
    overflow_d = overflow_q | (if_valid & ~flush & stall_fetch & ~pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; entries are only observable while count covers them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic [32:0] drop_sum;

  // Entries discarded by a flush exclude the one decode pops in that cycle.
  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + 33'(count_q) - 33'(pop);
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      drop_cnt_d = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign flush_drop_cnt = drop_cnt_q;
`endif

endmodule
